// File: rtl/trisc_bus_arbiter.sv
// Two-way round-robin arbiter for the TRISC memory port: grants CPU or I/O,
// drives a fixed-length MemRd/MemWr strobe, then pulses the owner's Done.
module trisc_bus_arbiter #(
    parameter int unsigned MEM_CYCLES = 3
) (
    input  logic SysClock_i,
    input  logic StartStop_i,
    input  logic CpuReq_i,
    input  logic CpuWr_i,
    input  logic IoReq_i,
    input  logic IoWr_i,
    output logic CpuGnt_o,
    output logic IoGnt_o,
    output logic BusSel_o,
    output logic MemRd_o,
    output logic MemWr_o,
    output logic CpuDone_o,
    output logic IoDone_o,
    output logic Busy_o
);

    if (MEM_CYCLES < 1 || MEM_CYCLES > 15) begin : g_bad_mem_cycles
        $error("trisc_bus_arbiter: MEM_CYCLES must be within 1..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(MEM_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;      // 0 = CPU, 1 = I/O
    logic       wr_q, wr_d;
    logic       last_io_q, last_io_d;  // 1 when I/O was the most recent owner

    logic cpu_gnt_q, cpu_gnt_d;
    logic io_gnt_q, io_gnt_d;
    logic mem_rd_q, mem_rd_d;
    logic mem_wr_q, mem_wr_d;
    logic cpu_done_q, cpu_done_d;
    logic io_done_q, io_done_d;
    logic busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        last_io_d = last_io_q;

        case (state_q)
            ST_IDLE: begin
                if (CpuReq_i || IoReq_i) begin
                    // On a tie the side that did not own the bus last goes first.
                    if (CpuReq_i && IoReq_i) begin
                        owner_d = ~last_io_q;
                    end else begin
                        owner_d = IoReq_i;
                    end
                    wr_d    = owner_d ? IoWr_i : CpuWr_i;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                last_io_d = owner_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are flop outputs
    // aligned with the state they describe.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        cpu_gnt_d  = busy_d && !owner_d;
        io_gnt_d   = busy_d && owner_d;
        mem_rd_d   = (state_d == ST_ACCESS) && !wr_d;
        mem_wr_d   = (state_d == ST_ACCESS) && wr_d;
        cpu_done_d = (state_d == ST_DONE) && !owner_d;
        io_done_d  = (state_d == ST_DONE) && owner_d;
    end

    always_ff @(negedge SysClock_i or posedge StartStop_i) begin
        if (StartStop_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            owner_q    <= 1'b0;
            wr_q       <= 1'b0;
            last_io_q  <= 1'b1;
            cpu_gnt_q  <= 1'b0;
            io_gnt_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            cpu_done_q <= 1'b0;
            io_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            last_io_q  <= last_io_d;
            cpu_gnt_q  <= cpu_gnt_d;
            io_gnt_q   <= io_gnt_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            cpu_done_q <= cpu_done_d;
            io_done_q  <= io_done_d;
            busy_q     <= busy_d;
        end
    end

    // The owner register only changes at grant, so it doubles as the
    // datapath select that holds its value through IDLE.
    assign BusSel_o  = owner_q;
    assign CpuGnt_o  = cpu_gnt_q;
    assign IoGnt_o   = io_gnt_q;
    assign MemRd_o   = mem_rd_q;
    assign MemWr_o   = mem_wr_q;
    assign CpuDone_o = cpu_done_q;
    assign IoDone_o  = io_done_q;
    assign Busy_o    = busy_q;

endmodule

// File: tb/tb_trisc_bus_arbiter.sv
// Bench for trisc_bus_arbiter: directed test-plan scenarios plus random
// traffic, checked against a transaction-timeline model (MEM_CYCLES 3 and 1).
module tb_trisc_bus_arbiter;

    logic clk = 1'b1;
    logic rst = 1'b1;
    logic cpu_req = 1'b0, cpu_wr = 1'b0, io_req = 1'b0, io_wr = 1'b0;

    logic cg3, ig3, bs3, rd3, wr3, cd3, id3, bz3;
    logic cg1, ig1, bs1, rd1, wr1, cd1, id1, bz1;
    logic [7:0] o3, o1;

    always #5 clk = ~clk;

    trisc_bus_arbiter #(.MEM_CYCLES(3)) dut3 (
        .SysClock_i(clk), .StartStop_i(rst),
        .CpuReq_i(cpu_req), .CpuWr_i(cpu_wr), .IoReq_i(io_req), .IoWr_i(io_wr),
        .CpuGnt_o(cg3), .IoGnt_o(ig3), .BusSel_o(bs3), .MemRd_o(rd3), .MemWr_o(wr3),
        .CpuDone_o(cd3), .IoDone_o(id3), .Busy_o(bz3)
    );

    trisc_bus_arbiter #(.MEM_CYCLES(1)) dut1 (
        .SysClock_i(clk), .StartStop_i(rst),
        .CpuReq_i(cpu_req), .CpuWr_i(cpu_wr), .IoReq_i(io_req), .IoWr_i(io_wr),
        .CpuGnt_o(cg1), .IoGnt_o(ig1), .BusSel_o(bs1), .MemRd_o(rd1), .MemWr_o(wr1),
        .CpuDone_o(cd1), .IoDone_o(id1), .Busy_o(bz1)
    );

    // {CpuGnt, IoGnt, BusSel, MemRd, MemWr, CpuDone, IoDone, Busy}
    assign o3 = {cg3, ig3, bs3, rd3, wr3, cd3, id3, bz3};
    assign o1 = {cg1, ig1, bs1, rd1, wr1, cd1, id1, bz1};

    int n_assert = 0;
    int n_fail   = 0;

    // Model: pos = cycles since grant (-1 when idle). Cycles 0..m-1 strobe,
    // cycle m is the Done cycle, after which one idle cycle always follows.
    typedef struct {
        int m;
        int pos;
        bit owner;
        bit wr;
        bit last_io;
        bit bussel;
    } mdl_t;

    mdl_t md3, md1;

    function automatic mdl_t mdl_reset(int m);
        mdl_t s;
        s.m = m; s.pos = -1; s.owner = 1'b0; s.wr = 1'b0;
        s.last_io = 1'b1; s.bussel = 1'b0;
        return s;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, logic cr, logic cw, logic ir, logic iw);
        mdl_t n = s;
        if (s.pos < 0) begin
            if (cr || ir) begin
                n.owner  = (cr && ir) ? !s.last_io : ir;
                n.wr     = n.owner ? iw : cw;
                n.bussel = n.owner;
                n.pos    = 0;
            end
        end else if (s.pos == s.m) begin
            n.last_io = s.owner;
            n.pos     = -1;
        end else begin
            n.pos = s.pos + 1;
        end
        return n;
    endfunction

    function automatic logic [7:0] mdl_out(mdl_t s);
        bit act, strobe, done;
        act    = (s.pos >= 0);
        strobe = act && (s.pos < s.m);
        done   = (s.pos == s.m);
        return {act && !s.owner, act && s.owner, s.bussel, strobe && !s.wr,
                strobe && s.wr, done && !s.owner, done && s.owner, act};
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One falling edge: advance both models on the inputs the DUTs see, then compare.
    task automatic tick();
        @(negedge clk);
        md3 = mdl_step(md3, cpu_req, cpu_wr, io_req, io_wr);
        md1 = mdl_step(md1, cpu_req, cpu_wr, io_req, io_wr);
        #1;
        check("model_m3", o3, mdl_out(md3));
        check("model_m1", o1, mdl_out(md1));
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_async_m3", o3, 8'h00);
        check("rst_async_m1", o1, 8'h00);
        md3 = mdl_reset(3);
        md1 = mdl_reset(1);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_cpu_rd [5];
        logic [7:0] exp_io_wr  [5];
        int grant_edge [4];
        bit grant_io   [4];
        int n_grant, edge_n, rd_cnt, wr_cnt, done_cnt;
        logic prev_busy;

        md3 = mdl_reset(3);
        md1 = mdl_reset(1);
        #2;
        check("reset_m3", o3, 8'h00);
        check("reset_m1", o1, 8'h00);
        #1;
        rst = 1'b0;

        // Single CPU read, MEM_CYCLES = 3
        exp_cpu_rd = '{8'b10010001, 8'b10010001, 8'b10010001, 8'b10000101, 8'b00000000};
        cpu_req = 1'b1; cpu_wr = 1'b0;
        for (int e = 0; e < 5; e++) begin
            tick();
            cpu_req = 1'b0;
            check($sformatf("cpu_rd_e%0d", e), o3, exp_cpu_rd[e]);
        end
        tick();

        // Single I/O write; BusSel holds 1 once back in IDLE
        exp_io_wr = '{8'b01101001, 8'b01101001, 8'b01101001, 8'b01100011, 8'b00100000};
        io_req = 1'b1; io_wr = 1'b1;
        for (int e = 0; e < 5; e++) begin
            tick();
            io_req = 1'b0;
            check($sformatf("io_wr_e%0d", e), o3, exp_io_wr[e]);
        end
        tick();

        // Reset in the middle of an I/O write, then a tie goes to the CPU
        io_req = 1'b1; io_wr = 1'b1;
        tick();
        tick();
        check("io_wr_mid", o3, 8'b01101001);
        do_reset();
        cpu_req = 1'b1; cpu_wr = 1'b0;
        io_req  = 1'b1; io_wr  = 1'b0;
        tick();
        check("tie_after_rst", o3, 8'b10010001);

        // Contention continues: four grants alternating, 5 cycles apart
        n_grant = 1; grant_edge[0] = 0; grant_io[0] = ig3;
        prev_busy = bz3;
        for (int e = 1; e < 20; e++) begin
            tick();
            if (bz3 && !prev_busy && n_grant < 4) begin
                grant_edge[n_grant] = e;
                grant_io[n_grant]   = ig3;
                n_grant++;
            end
            prev_busy = bz3;
        end
        check("contention_grants", 8'(n_grant), 8'd4);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("contention_owner%0d", g), {7'd0, grant_io[g]}, {7'd0, g[0]});
            if (g > 0)
                check($sformatf("contention_gap%0d", g),
                      8'(grant_edge[g] - grant_edge[g-1]), 8'd5);
        end
        cpu_req = 1'b0; io_req = 1'b0;
        for (int e = 0; e < 6; e++) tick();

        // Request withdrawn and type flipped after grant: still a full read
        cpu_req = 1'b1; cpu_wr = 1'b0;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        for (int e = 0; e < 6; e++) begin
            tick();
            cpu_req = 1'b0; cpu_wr = 1'b1;
            rd_cnt   += int'(rd3);
            wr_cnt   += int'(wr3);
            done_cnt += int'(cd3);
        end
        check("withdraw_rd_cycles", 8'(rd_cnt), 8'd3);
        check("withdraw_wr_cycles", 8'(wr_cnt), 8'd0);
        check("withdraw_done", 8'(done_cnt), 8'd1);
        cpu_wr = 1'b0;

        // MEM_CYCLES = 1 with CPU request held: period of 3 cycles
        cpu_req = 1'b1;
        rd_cnt = 0; done_cnt = 0; edge_n = 0;
        for (int e = 0; e < 9; e++) begin
            tick();
            rd_cnt   += int'(rd1);
            done_cnt += int'(cd1);
            if (e == 2) check("m1_idle_gap", o1, 8'h00);
        end
        check("m1_rd_cycles", 8'(rd_cnt), 8'd3);
        check("m1_done_pulses", 8'(done_cnt), 8'd3);
        cpu_req = 1'b0;
        for (int e = 0; e < 6; e++) tick();

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 500; i++) begin
            cpu_req = ($urandom_range(0, 3) != 0);
            io_req  = ($urandom_range(0, 3) != 0);
            cpu_wr  = 1'($urandom_range(0, 1));
            io_wr   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) do_reset();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
